// File: rtl/uart_pkg.sv
`timescale 1ns/1ps
// Shared types, constants and helpers for the 8N1 UART receiver and its
// companion baud-tick generator.
package uart_pkg;

    // Receiver frame-tracking states
    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_HIGH
    } rx_state_t;

    // Ticks per bit period
    localparam int OVERSAMPLE = 16;

    // Oversample positions inside a bit (s_cnt values)
    localparam logic [3:0] SAMPLE_A  = 4'd7;
    localparam logic [3:0] SAMPLE_B  = 4'd8;
    localparam logic [3:0] SAMPLE_C  = 4'd9;   // majority decision point
    localparam logic [3:0] LAST_TICK = 4'd15;  // last tick of a bit

    localparam int DATA_BITS = 8;

    // Clock cycles per oversample tick (integer floor)
    function automatic int calc_div(input int clk_freq, input int baud);
        return clk_freq / (baud * OVERSAMPLE);
    endfunction

    // Two-out-of-three vote
    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
`timescale 1ns/1ps
// Oversample tick generator: one-clock tick every DIV clocks while enabled.
// The counter sits at 0 while disabled so the first tick after enabling
// lands exactly DIV clocks later, phase-aligning it to the enabling event.
module uart_baud_tick
    import uart_pkg::*;
#(
    parameter int CLK_FREQ = 50000000,
    parameter int BAUD     = 9600
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    output logic tick
);

    localparam int DIV = calc_div(CLK_FREQ, BAUD);
    localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Next count and tick strobe
    always_comb begin
        cnt_d = cnt_q;
        tick  = 1'b0;
        if (!en) begin
            cnt_d = '0;
        end else if (cnt_q == LAST) begin
            cnt_d = '0;
            tick  = 1'b1;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    // Divider counter register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_rx_dzj.sv
`timescale 1ns/1ps
// 8N1 UART receiver: 16x oversampling with a 3-sample majority vote per bit,
// valid/ready byte output, and false-start / framing / overrun detection.
module uart_rx_dzj
    import uart_pkg::*;
#(
    parameter int CLK_FREQ = 50000000,
    parameter int BAUD     = 9600
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    input  logic       rx_ready,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rx_busy,
    output logic       frame_err,
    output logic       overrun
);

    // sync_q[0], sync_q[1]: two-flop synchroniser; sync_q[2]: previous rx_s
    logic [2:0] sync_q;
    logic [2:0] sync_d;
    logic       rx_s;
    logic       rx_prev;

    rx_state_t  state_q, state_d;
    logic [3:0] s_cnt_q, s_cnt_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic [1:0] samp_q, samp_d;
    logic [7:0] shift_q, shift_d;
    logic [7:0] rx_data_q, rx_data_d;
    logic       rx_valid_q, rx_valid_d;
    logic       frame_err_q, frame_err_d;
    logic       overrun_q, overrun_d;

    logic       tick;
    logic       tick_en;
    logic       maj;
    logic       deliver;

    assign rx_s    = sync_q[1];
    assign rx_prev = sync_q[2];
    assign tick_en = (state_q == START) || (state_q == DATA) || (state_q == STOP);

    uart_baud_tick #(
        .CLK_FREQ (CLK_FREQ),
        .BAUD     (BAUD)
    ) u_tick (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (tick_en),
        .tick  (tick)
    );

    // Shift the raw line through the synchroniser and edge-history flop
    always_comb begin
        sync_d = {sync_q[1:0], rx};
    end

    // Synchroniser registers, idle-high at reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= 3'b111;
        end else begin
            sync_q <= sync_d;
        end
    end

    // Frame FSM, bit sampling and output handshake
    always_comb begin
        state_d     = state_q;
        s_cnt_d     = s_cnt_q;
        bit_cnt_d   = bit_cnt_q;
        samp_d      = samp_q;
        shift_d     = shift_q;
        rx_data_d   = rx_data_q;
        rx_valid_d  = rx_valid_q;
        frame_err_d = 1'b0;
        overrun_d   = 1'b0;
        deliver     = 1'b0;
        maj         = maj3(samp_q[0], samp_q[1], rx_s);

        case (state_q)
            IDLE: begin
                s_cnt_d   = '0;
                bit_cnt_d = '0;
                if (rx_prev && !rx_s) begin
                    state_d = START;
                end
            end
            START, DATA, STOP: begin
                if (tick) begin
                    s_cnt_d = s_cnt_q + 4'd1;
                    if (s_cnt_q == SAMPLE_A) begin
                        samp_d[0] = rx_s;
                    end
                    if (s_cnt_q == SAMPLE_B) begin
                        samp_d[1] = rx_s;
                    end
                    if (s_cnt_q == SAMPLE_C) begin
                        if (state_q == START) begin
                            // A start bit that reads high is line noise
                            if (maj) begin
                                state_d = IDLE;
                            end
                        end else if (state_q == DATA) begin
                            shift_d = {maj, shift_q[7:1]};
                        end else begin
                            // Stop bit decided mid-bit so the next start
                            // edge can be caught without an idle gap
                            if (maj) begin
                                deliver = 1'b1;
                                state_d = IDLE;
                            end else begin
                                frame_err_d = 1'b1;
                                state_d     = WAIT_HIGH;
                            end
                        end
                    end
                    if (s_cnt_q == LAST_TICK) begin
                        if (state_q == START) begin
                            state_d   = DATA;
                            bit_cnt_d = '0;
                        end else if (state_q == DATA) begin
                            if (bit_cnt_q == 3'(DATA_BITS - 1)) begin
                                state_d   = STOP;
                                bit_cnt_d = '0;
                            end else begin
                                bit_cnt_d = bit_cnt_q + 3'd1;
                            end
                        end
                    end
                end
            end
            WAIT_HIGH: begin
                // Hold off while the line is broken/low
                if (rx_s) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (rx_valid_q && rx_ready) begin
            rx_valid_d = 1'b0;
        end
        if (deliver) begin
            if (!rx_valid_q || rx_ready) begin
                rx_data_d  = shift_q;
                rx_valid_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end
    end

    // State, counters, data path and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            s_cnt_q     <= '0;
            bit_cnt_q   <= '0;
            samp_q      <= '0;
            shift_q     <= '0;
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            s_cnt_q     <= s_cnt_d;
            bit_cnt_q   <= bit_cnt_d;
            samp_q      <= samp_d;
            shift_q     <= shift_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
        end
    end

    assign rx_data   = rx_data_q;
    assign rx_valid  = rx_valid_q;
    assign rx_busy   = (state_q != IDLE);
    assign frame_err = frame_err_q;
    assign overrun   = overrun_q;

endmodule
